// File: rtl/address_gen_unit_if.sv
// Bus bundle between an address generator and its requester/memory side.
// The slave modport is the generator's view; master is the driving side.
interface address_gen_unit_if #(
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned BW        = $clog2(MAX_BEATS + 1)
) ();
    logic          start;
    logic [1:0]    addr_sel;
    logic [1:0]    size;
    logic [BW-1:0] burst_len;
    logic          calc_en;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] reg_a;
    logic [AW-1:0] a_op;
    logic [AW-1:0] b_op;
    logic          bus_ready;

    logic          bus_valid;
    logic [AW-1:0] address;
    logic [1:0]    data_select;
    logic          beat_last;
    logic [AW-1:0] calculated_address;
    logic          busy;
    logic          misalign;

    modport slave (
        input  start, addr_sel, size, burst_len, calc_en,
        input  next_pc, reg_a, a_op, b_op, bus_ready,
        output bus_valid, address, data_select, beat_last,
        output calculated_address, busy, misalign
    );

    modport master (
        output start, addr_sel, size, burst_len, calc_en,
        output next_pc, reg_a, a_op, b_op, bus_ready,
        input  bus_valid, address, data_select, beat_last,
        input  calculated_address, busy, misalign
    );
endinterface

// File: rtl/address_gen_unit.sv
// Burst address generator: selects a base, checks alignment, then issues
// incrementing beat addresses under a valid/ready handshake.
module address_gen_unit #(
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned BW        = $clog2(MAX_BEATS + 1)
) (
    input logic                 clk,
    input logic                 reset,
    address_gen_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [AW-1:0] r_address;
    logic [BW-1:0] r_beats_left;
    logic [1:0]    r_size;
    logic          r_misalign;
    logic [AW-1:0] r_calc;

    logic [AW-1:0] w_sum;
    logic [AW-1:0] w_base;
    logic [1:0]    w_size_eff;
    logic          w_misalign;
    logic [BW-1:0] w_eff_len;
    logic [AW-1:0] w_incr;
    logic          w_load;
    logic          w_advance;
    logic          w_fault;

    assign w_sum = bus.a_op + bus.b_op;

    always_comb begin
        w_base = bus.next_pc;
        case (bus.addr_sel)
            2'd1:    w_base = bus.reg_a;
            2'd2:    w_base = w_sum;
            default: w_base = bus.next_pc;
        endcase
    end

    assign w_size_eff = (bus.size == 2'd3) ? 2'd2 : bus.size;

    always_comb begin
        w_misalign = 1'b0;
        if (w_size_eff == 2'd1)
            w_misalign = w_base[0];
        else if (w_size_eff == 2'd2)
            w_misalign = (w_base[1:0] != 2'b00);
    end

    // A zero length still issues one beat; oversize lengths saturate.
    always_comb begin
        w_eff_len = bus.burst_len;
        if (bus.burst_len == '0)
            w_eff_len = BW'(1);
        else if (bus.burst_len > BW'(MAX_BEATS))
            w_eff_len = BW'(MAX_BEATS);
    end

    // Stride uses the size captured at start so mid-burst size changes are ignored.
    assign w_incr = {{(AW-1){1'b0}}, 1'b1} << r_size;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_misalign) begin
                        w_fault      = 1'b1;
                        w_next_state = FAULT;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.bus_ready) begin
                    if (r_beats_left == '0)
                        w_next_state = IDLE;
                    else
                        w_advance = 1'b1;
                end
            end
            FAULT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address    <= '0;
            r_beats_left <= '0;
            r_size       <= '0;
            r_misalign   <= 1'b0;
        end else begin
            if (w_load) begin
                r_address    <= w_base;
                r_beats_left <= w_eff_len - BW'(1);
                r_size       <= w_size_eff;
                r_misalign   <= 1'b0;
            end else if (w_advance) begin
                r_address    <= r_address + w_incr;
                r_beats_left <= r_beats_left - BW'(1);
            end
            if (w_fault)
                r_misalign <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_calc <= '0;
        else if (bus.calc_en)
            r_calc <= w_sum;
    end

    assign bus.bus_valid          = (r_state == ISSUE);
    assign bus.busy               = (r_state != IDLE);
    assign bus.beat_last          = (r_state == ISSUE) && (r_beats_left == '0);
    assign bus.address            = r_address;
    assign bus.data_select        = r_address[1:0];
    assign bus.calculated_address = r_calc;
    assign bus.misalign           = r_misalign;

endmodule

// File: tb/tb_address_gen_unit.sv
// Directed self-checking bench for address_gen_unit with hand-computed
// beat address sequences.
module tb_address_gen_unit;

    localparam int unsigned AW        = 32;
    localparam int unsigned MAX_BEATS = 8;
    localparam int unsigned BW        = $clog2(MAX_BEATS + 1);

    logic clk;
    logic reset;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [31:0] exp_a [8];

    address_gen_unit_if #(.AW(AW), .MAX_BEATS(MAX_BEATS)) bus ();

    address_gen_unit #(
        .AW        (AW),
        .MAX_BEATS (MAX_BEATS),
        .BW        (BW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] addr);
        check({tag, "_valid"}, 32'(bus.bus_valid), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_last"},  32'(bus.beat_last), 32'd0);
        check({tag, "_addr"},  bus.address,        addr);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] addr, input logic last);
        check({tag, "_valid"}, 32'(bus.bus_valid),   32'd1);
        check({tag, "_addr"},  bus.address,          addr);
        check({tag, "_dsel"},  32'(bus.data_select), 32'(addr[1:0]));
        check({tag, "_last"},  32'(bus.beat_last),   32'(last));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.addr_sel  = 2'd0;
        bus.size      = 2'd0;
        bus.burst_len = '0;
        bus.calc_en   = 1'b0;
        bus.next_pc   = '0;
        bus.reg_a     = '0;
        bus.a_op      = '0;
        bus.b_op      = '0;
        bus.bus_ready = 1'b1;
        tick();
        tick();

        check_idle("rst", 32'h0);
        check("rst_dsel", 32'(bus.data_select), 32'd0);
        check("rst_mis",  32'(bus.misalign), 32'd0);
        check("rst_calc", bus.calculated_address, 32'h0);
        reset = 1'b0;
        tick();

        // Four word beats from next_pc
        bus.addr_sel  = 2'd0;
        bus.next_pc   = 32'h100;
        bus.size      = 2'd2;
        bus.burst_len = BW'(4);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("b4_%0d", i), 32'h100 + 32'(4 * i), i == 3);
            tick();
        end
        check_idle("b4_end", 32'h10C);

        // Misaligned half-word from a_op+b_op, with a calc_en capture
        bus.addr_sel = 2'd2;
        bus.a_op     = 32'h1000;
        bus.b_op     = 32'h3;
        bus.size     = 2'd1;
        bus.calc_en  = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.calc_en = 1'b0;
        check("flt_busy",  32'(bus.busy),      32'd1);
        check("flt_valid", 32'(bus.bus_valid), 32'd0);
        check("flt_mis",   32'(bus.misalign),  32'd1);
        check("flt_addr",  bus.address,        32'h10C);
        check("calc_load", bus.calculated_address, 32'h1003);
        bus.a_op = 32'h2000;
        tick();
        check_idle("flt_end", 32'h10C);
        check("flt_mis_sticky", 32'(bus.misalign), 32'd1);
        check("calc_hold", bus.calculated_address, 32'h1003);

        // Aligned start clears the sticky flag
        bus.a_op      = 32'h1000;
        bus.b_op      = 32'h4;
        bus.size      = 2'd2;
        bus.burst_len = BW'(1);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("clr_mis", 32'(bus.misalign), 32'd0);
        check_beat("clr", 32'h1004, 1'b1);
        tick();
        check_idle("clr_end", 32'h1004);

        // Byte burst from reg_a with a two-cycle stall on the second beat
        bus.addr_sel  = 2'd1;
        bus.reg_a     = 32'h20;
        bus.size      = 2'd0;
        bus.burst_len = BW'(3);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check_beat("stl_0", 32'h20, 1'b0);
        tick();
        check_beat("stl_1", 32'h21, 1'b0);
        bus.bus_ready = 1'b0;
        tick();
        check_beat("stl_h1", 32'h21, 1'b0);
        tick();
        check_beat("stl_h2", 32'h21, 1'b0);
        bus.bus_ready = 1'b1;
        tick();
        check_beat("stl_2", 32'h22, 1'b1);
        tick();
        check_idle("stl_end", 32'h22);

        // Wrap past the top of the address space; sel=3 and size=3 alias NEXTPC/word
        bus.addr_sel  = 2'd3;
        bus.next_pc   = 32'hFFFF_FFF8;
        bus.size      = 2'd3;
        bus.burst_len = BW'(3);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("wrp_%0d", i), exp_a[i], i == 2);
            check($sformatf("wrp_mis_%0d", i), 32'(bus.misalign), 32'd0);
            tick();
        end
        check_idle("wrp_end", 32'h0);

        // Zero length gives a single beat
        bus.addr_sel  = 2'd0;
        bus.next_pc   = 32'h200;
        bus.size      = 2'd2;
        bus.burst_len = '0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check_beat("len0", 32'h200, 1'b1);
        tick();
        check_idle("len0_end", 32'h200);

        // Oversize length clamps to MAX_BEATS; a start pulse mid-burst is ignored
        bus.next_pc   = 32'h300;
        bus.burst_len = BW'(15);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_beat($sformatf("len15_%0d", i), 32'h300 + 32'(4 * i), i == 7);
            if (i == 2) begin
                bus.next_pc = 32'h800;
                bus.start   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        check_idle("len15_end", 32'h31C);

        // Asynchronous reset on the second beat of four
        bus.next_pc   = 32'h100;
        bus.burst_len = BW'(4);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check_beat("ar_0", 32'h100, 1'b0);
        tick();
        check_beat("ar_1", 32'h104, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_idle("ar_now", 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check_idle("ar_rel", 32'h0);
        tick();
        check_idle("ar_rel2", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
